fft_out_packer: RTL and testbench

Stream packer between the FFT/IFFT core output and the write DMA. Accepts 32-bit complex samples over a valid/ready handshake, packs two samples per 64-bit AXI data word, and buffers the words in a small FIFO. The FIFO presents the show-ahead `dout`/`empty_n`/`read` interface that the write DMA consumes. A per-job sample count is programmed at start; an odd final sample is zero-padded to a full word.

---
 rtl/fft_dma_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/fft_out_packer.sv | 113 +++++++++++
 tb/tb_fft_out_packer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_dma_pkg.sv
// Shared definitions for the FFT output DMA path: default widths, packer FSM encoding
// and the {im, re} field layout of a complex sample.
package fft_dma_pkg;

  localparam int unsigned PKG_DATA_WIDTH   = 64;
  localparam int unsigned PKG_SAMPLE_WIDTH = 32;

  localparam int unsigned SAMPLE_RE_LSB = 0;
  localparam int unsigned SAMPLE_RE_W   = 16;
  localparam int unsigned SAMPLE_IM_LSB = 16;
  localparam int unsigned SAMPLE_IM_W   = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_PAD  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. The head word is visible on m_data whenever m_valid is
// high; s_ready is derived from the registered occupancy only.
module sync_fifo #(
  parameter int unsigned FIFO_IN_REG     = 0,
  parameter int unsigned FIFO_OUT_REG    = 0,
  parameter int unsigned FIFO_CMD_LENGTH = 64,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned FIFO_LOG2_DEPTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [FIFO_CMD_LENGTH-1:0] s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [FIFO_CMD_LENGTH-1:0] m_data
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Only the unregistered configuration exists; both stage options must be 0.
  if (FIFO_IN_REG != 0 || FIFO_OUT_REG != 0) begin : g_cfg_unsupported
  end

  logic [FIFO_CMD_LENGTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG2_DEPTH-1:0] count_q, count_d;
  logic                       push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign s_ready = (count_q < FIFO_LOG2_DEPTH'(FIFO_DEPTH));
  assign m_valid = (count_q != '0);
  assign push    = s_valid & s_ready;
  assign pop     = m_ready & m_valid;
  assign m_data  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + FIFO_LOG2_DEPTH'(1);
      2'b01:   count_d = count_q - FIFO_LOG2_DEPTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

endmodule

// File: rtl/fft_out_packer.sv
// Packs pairs of 32-bit complex samples into 64-bit words (first sample in the low half)
// and queues them for the write DMA; an odd trailing sample is zero-padded.
module fft_out_packer
  import fft_dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = PKG_DATA_WIDTH,
  parameter int unsigned SAMPLE_WIDTH    = PKG_SAMPLE_WIDTH,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned FIFO_LOG2_DEPTH = 5,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    num_samples,
  output logic                    busy,
  output logic                    done,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SAMPLE_WIDTH-1:0] s_data,
  output logic [DATA_WIDTH-1:0]   out_dout,
  output logic                    out_empty_n,
  input  logic                    out_read
);

  state_e                  state_q, state_d;
  logic                    start_q;
  logic [CNT_WIDTH-1:0]    total_q, total_d, acc_cnt_q, acc_cnt_d;
  logic                    lane_q, lane_d;
  logic [SAMPLE_WIDTH-1:0] low_q, low_d;

  logic                  start_edge, accept, last_accept;
  logic                  fifo_push, fifo_s_ready, fifo_m_valid;
  logic [DATA_WIDTH-1:0] fifo_s_data, fifo_m_data;

  assign start_edge  = start & ~start_q;
  assign accept      = s_valid & s_ready;
  assign last_accept = accept & ((acc_cnt_q + CNT_WIDTH'(1)) == total_q);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      total_q   <= '0;
      acc_cnt_q <= '0;
      lane_q    <= 1'b0;
      low_q     <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      total_q   <= total_d;
      acc_cnt_q <= acc_cnt_d;
      lane_q    <= lane_d;
      low_q     <= low_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_edge) state_d = (num_samples == '0) ? S_DONE : S_RUN;
      S_RUN:  if (last_accept) state_d = lane_q ? S_DONE : S_PAD;
      S_PAD:  if (fifo_s_ready) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Job bookkeeping; counters are held clear while idle so each job starts in lane 0.
  always_comb begin
    total_d   = total_q;
    acc_cnt_d = acc_cnt_q;
    lane_d    = lane_q;
    low_d     = low_q;
    if (state_q == S_IDLE) begin
      acc_cnt_d = '0;
      lane_d    = 1'b0;
      if (start_edge) total_d = num_samples;
    end else if (accept) begin
      acc_cnt_d = acc_cnt_q + CNT_WIDTH'(1);
      lane_d    = ~lane_q;
      if (!lane_q) low_d = s_data;
    end
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    s_ready     = (state_q == S_RUN) && (acc_cnt_q < total_q) && (!lane_q || fifo_s_ready);
    fifo_push   = ((state_q == S_RUN) && accept && lane_q) || ((state_q == S_PAD) && fifo_s_ready);
    fifo_s_data = (state_q == S_PAD) ? {{SAMPLE_WIDTH{1'b0}}, low_q} : {s_data, low_q};
    out_empty_n = fifo_m_valid;
    out_dout    = fifo_m_valid ? fifo_m_data : '0;
  end

  sync_fifo #(
    .FIFO_IN_REG    (0),
    .FIFO_OUT_REG   (0),
    .FIFO_CMD_LENGTH(DATA_WIDTH),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .FIFO_LOG2_DEPTH(FIFO_LOG2_DEPTH)
  ) u_fifo (
    .clk    (ap_clk),
    .rst    (ap_rst),
    .s_valid(fifo_push),
    .s_ready(fifo_s_ready),
    .s_data (fifo_s_data),
    .m_valid(fifo_m_valid),
    .m_ready(out_read),
    .m_data (fifo_m_data)
  );

endmodule

// File: tb/tb_fft_out_packer.sv
// Scenario bench for fft_out_packer: expected words are built from the sample lists when a
// job is launched and compared in order as the DMA side pops them.
module tb_fft_out_packer;
  import fft_dma_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned SW = 32;
  localparam int unsigned CW = 32;

  logic          ap_clk = 1'b0;
  logic          ap_rst, start, busy, done, s_valid, s_ready, out_empty_n, out_read;
  logic [CW-1:0] num_samples;
  logic [SW-1:0] s_data;
  logic [DW-1:0] out_dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_popped = 0;

  logic [DW-1:0] exp_q[$];
  logic [SW-1:0] smp_q[$];
  logic [DW-1:0] mon_exp;

  fft_out_packer dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .start      (start),
    .num_samples(num_samples),
    .busy       (busy),
    .done       (done),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .out_dout   (out_dout),
    .out_empty_n(out_empty_n),
    .out_read   (out_read)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  // Scoreboard: every word popped by the DMA side must match the oldest expected word.
  always @(negedge ap_clk) begin
    if (!ap_rst && out_read && out_empty_n) begin
      checks++;
      n_popped++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h, required no word", out_dout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_dout !== mon_exp) begin
          errors++;
          $display("FAIL pop_word: got %h, required %h", out_dout, mon_exp);
        end
      end
    end
  end

  function automatic logic [SW-1:0] mk_sample(input int unsigned re, input int unsigned im);
    logic [SW-1:0] s;
    s = '0;
    s[SAMPLE_RE_LSB +: SAMPLE_RE_W] = SAMPLE_RE_W'(re);
    s[SAMPLE_IM_LSB +: SAMPLE_IM_W] = SAMPLE_IM_W'(im);
    return s;
  endfunction

  task automatic load_expected();
    for (int i = 0; i < smp_q.size(); i += 2) begin
      logic [SW-1:0] hi;
      hi = (i + 1 < smp_q.size()) ? smp_q[i+1] : '0;
      exp_q.push_back({hi, smp_q[i]});
    end
  endtask

  task automatic start_job(input int unsigned n);
    num_samples = n;
    start = 1'b1;
    @(posedge ap_clk); #1;
    start = 1'b0;
  endtask

  // Present one sample and return #1 after the edge that accepted it.
  task automatic send(input logic [SW-1:0] d, input string tag);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data = d;
    for (int w = 0; w < 64; w++) begin
      @(negedge ap_clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_accept: s_ready stayed %b, required 1 within 64 cycles", tag, s_ready);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic wait_drain(input string tag);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || out_empty_n) && w < 200) begin
      @(posedge ap_clk); #1;
      w++;
    end
    checks++;
    if (exp_q.size() != 0 || out_empty_n) begin
      errors++;
      $display("FAIL %s_drain: %0d words missing, out_empty_n=%b, required 0 and 0",
               tag, exp_q.size(), out_empty_n);
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
    if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b, required 0", s_ready); end
    if (out_empty_n !== 1'b0) begin
      errors++; $display("FAIL rst_empty_n: got %b, required 0", out_empty_n);
    end
    if (out_dout !== '0) begin errors++; $display("FAIL rst_dout: got %h, required 0", out_dout); end
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
  endtask

  task automatic test_even();
    int t0;
    out_read = 1'b1;
    smp_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    load_expected();
    start_job(4);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL even_busy: got %b, required 1", busy); end
    t0 = 0;
    for (int i = 0; i < 4; i++) begin
      send(smp_q[i], "even");
      if (i == 0) t0 = cyc;
      if (i == 1) begin
        checks++;
        if (out_empty_n !== 1'b1) begin
          errors++; $display("FAIL even_word_latency: out_empty_n=%b, required 1", out_empty_n);
        end
      end
    end
    checks += 2;
    if (done !== 1'b1) begin errors++; $display("FAIL even_done: got %b, required 1", done); end
    if (cyc - t0 != 3) begin
      errors++; $display("FAIL even_throughput: got %0d cycles, required 3", cyc - t0);
    end
    s_valid = 1'b0;
    @(posedge ap_clk); #1;
    checks += 2;
    if (done !== 1'b0) begin errors++; $display("FAIL even_done_pulse: got %b, required 0", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL even_busy_end: got %b, required 0", busy); end
    wait_drain("even");
  endtask

  task automatic test_odd();
    out_read = 1'b1;
    smp_q = '{32'h11111111, 32'h22222222, 32'h33333333};
    load_expected();
    start_job(3);
    for (int i = 0; i < 3; i++) send(smp_q[i], "odd");
    s_valid = 1'b0;
    checks += 2;
    if (done !== 1'b0) begin errors++; $display("FAIL odd_done_early: got %b, required 0", done); end
    if (busy !== 1'b1) begin errors++; $display("FAIL odd_busy_pad: got %b, required 1", busy); end
    @(posedge ap_clk); #1;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL odd_done: got %b, required 1", done); end
    @(posedge ap_clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL odd_busy_end: got %b, required 0", busy); end
    wait_drain("odd");
  endtask

  task automatic test_zero();
    int p0;
    out_read = 1'b1;
    p0 = n_popped;
    start_job(0);
    checks += 2;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b, required 1", done); end
    if (s_ready !== 1'b0) begin errors++; $display("FAIL zero_s_ready: got %b, required 0", s_ready); end
    @(posedge ap_clk); #1;
    checks += 3;
    if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b, required 0", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b, required 0", busy); end
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL zero_s_ready_idle: got %b, required 0", s_ready);
    end
    repeat (2) @(posedge ap_clk);
    #1;
    checks += 2;
    if (out_empty_n !== 1'b0) begin
      errors++; $display("FAIL zero_no_push: out_empty_n=%b, required 0", out_empty_n);
    end
    if (n_popped != p0) begin
      errors++; $display("FAIL zero_pops: got %0d words, required 0", n_popped - p0);
    end
  endtask

  task automatic test_backpressure();
    int p0;
    out_read = 1'b0;
    p0 = n_popped;
    smp_q.delete();
    for (int i = 1; i <= 40; i++) smp_q.push_back(mk_sample(i, 16'hA000 + i));
    load_expected();
    start_job(40);
    // 32 samples fill the 16 words; the 33rd still lands in lane 0.
    for (int i = 0; i < 33; i++) send(smp_q[i], "bp_fill");
    s_valid = 1'b1;
    s_data = smp_q[33];
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      checks += 2;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: s_ready=%b, required 0", s_ready); end
      if (out_empty_n !== 1'b1) begin
        errors++; $display("FAIL bp_full_empty_n: got %b, required 1", out_empty_n);
      end
    end
    @(posedge ap_clk); #1;
    out_read = 1'b1;
    for (int i = 33; i < 40; i++) send(smp_q[i], "bp_drain");
    s_valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b, required 1", done); end
    wait_drain("bp");
    checks++;
    if (n_popped - p0 != 20) begin
      errors++; $display("FAIL bp_word_count: got %0d words, required 20", n_popped - p0);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    out_read = 1'b0;
    smp_q.delete();
    for (int i = 0; i < 8; i++) smp_q.push_back(32'hC0DE0000 + i);
    start_job(8);
    for (int i = 0; i < 5; i++) send(smp_q[i], "rstmid");
    s_valid = 1'b0;
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b, required 0", done); end
    if (s_ready !== 1'b0) begin errors++; $display("FAIL rstmid_s_ready: got %b, required 0", s_ready); end
    if (out_empty_n !== 1'b0) begin
      errors++; $display("FAIL rstmid_empty_n: got %b, required 0", out_empty_n);
    end
    if (out_dout !== '0) begin errors++; $display("FAIL rstmid_dout: got %h, required 0", out_dout); end
    ap_rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got %b, required 0", done); end
    end
    @(posedge ap_clk); #1;
    out_read = 1'b1;
    p0 = n_popped;
    smp_q = '{32'hAAAA5555, 32'h1234ABCD};
    load_expected();
    start_job(2);
    for (int i = 0; i < 2; i++) send(smp_q[i], "rstmid_new");
    s_valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL rstmid_new_done: got %b, required 1", done); end
    wait_drain("rstmid");
    checks++;
    if (n_popped - p0 != 1) begin
      errors++; $display("FAIL rstmid_word_count: got %0d words, required 1", n_popped - p0);
    end
  endtask

  task automatic test_start_ignored();
    out_read = 1'b1;
    smp_q = '{32'h0F0F0001, 32'h0F0F0002, 32'h0F0F0003, 32'h0F0F0004};
    load_expected();
    start_job(4);
    send(smp_q[0], "ign");
    num_samples = 2;
    start = 1'b1;
    send(smp_q[1], "ign");
    send(smp_q[2], "ign");
    checks += 2;
    if (done !== 1'b0) begin errors++; $display("FAIL ign_done_early: got %b, required 0", done); end
    if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b, required 1", busy); end
    send(smp_q[3], "ign");
    s_valid = 1'b0;
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL ign_done: got %b, required 1", done); end
    @(posedge ap_clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_end: got %b, required 0", busy); end
    wait_drain("ign");
  endtask

  initial begin
    ap_rst = 1'b1;
    start = 1'b0;
    num_samples = '0;
    s_valid = 1'b0;
    s_data = '0;
    out_read = 1'b0;
    test_reset();
    test_even();
    test_odd();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
